multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller for the multicycle variant of the MIPS datapath: the shared-memory, single-ALU core that replaces the single-cycle top level. It is a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write strobe in the datapath, stalls on a memory ready handshake, and counts retired instructions. Illegal opcodes trap into a sticky halt state.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- i_Clk  in  1  clock, rising edge
- i_Rst_n  in  1  reset, asynchronous, active-low
- i_Opcode  in  6  IR[31:26]; must be stable from DECODE onward
- i_Zero  in  1  ALU zero flag, combinational in the current cycle
- i_MemReady  in  1  memory completes the current access this cycle
- o_PCEn  out  1  PC register write enable
- o_IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- o_MemRead / o_MemWrite  out  1 each  memory strobes
- o_IRWrite  out  1  instruction register load
- o_MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- o_RegDst  out  1  write register: 0 = rt, 1 = rd
- o_RegWrite  out  1  register file write
- o_ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs
- o_ALUSrcB  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- o_ALUOp  out  2  00 = add, 01 = sub, 10 = decode funct
- o_PCSource  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- o_State  out  4  current state encoding
- o_Illegal  out  1  sticky illegal-opcode flag
- o_Retired  out  COUNT_WIDTH  retired-instruction count

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, ILLEGAL=12. Codes 13-15 are unreachable; if entered, the next state is FETCH.
- Any output not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. While i_MemReady=0, stay in FETCH. When i_MemReady=1, assert IRWrite=1 and PCEn=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes the branch target). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 (lw) or 101011 (sw) -> MEMADDR
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> IEXEC
  - any other opcode -> ILLEGAL
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD=1, MemRead=1. Hold until i_MemReady=1, then go to MEMWB.
- MEMWB: MemtoReg=1, RegDst=0, RegWrite=1. Retire, go to FETCH.
- MEMWRITE: IorD=1, MemWrite=1. Hold until i_MemReady=1, then retire and go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB: RegDst=1, RegWrite=1. Retire, go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCEn = i_Zero XOR i_Opcode[0], so beq takes on zero and bne takes on nonzero. Retire, go to FETCH.
- JUMP: PCSource=10, PCEn=1. Retire, go to FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to IWB.
- IWB: RegDst=0, RegWrite=1. Retire, go to FETCH.
- ILLEGAL: all strobes 0, o_Illegal=1. The FSM stays here until reset.
- Retire: o_Retired increments by 1 on the clock edge that leaves a retiring state. It wraps from 2^COUNT_WIDTH-1 to 0. Instructions that enter ILLEGAL are not counted.

## Timing
- Reset values: state=FETCH, o_Retired=0, o_Illegal=0.
- While i_Rst_n=0, o_PCEn, o_MemRead, o_MemWrite, o_IRWrite and o_RegWrite are forced to 0. All select outputs take their FETCH values.
- Reset assertion takes effect immediately and aborts any in-flight instruction. An aborted instruction is not counted.
- After reset release, the first rising edge is evaluated in FETCH.
- Cycles per instruction with zero wait states: lw=5, sw=4, R-type=4, addi=4, beq/bne=3, j=3.
- Each cycle with i_MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Strobes are held constant across wait cycles.
- i_MemReady is ignored in every other state.
- o_PCEn in FETCH and BRANCH, and o_IRWrite in FETCH, are combinational from inputs. All other outputs depend only on state.

## Test plan
- Reset mid-MEMREAD: drop i_Rst_n -> o_State=0 and all strobes 0 immediately; o_Retired=0.
- Back-to-back R-type, addi, j with i_MemReady=1 -> o_State sequences 0,1,6,7,0,1,10,11,0,1,9,0. o_Retired=3 after 11 cycles.
- lw with i_MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD -> total 10 cycles. o_MemRead and o_IorD are stable during the waits. o_IRWrite pulses exactly once.
- beq with i_Zero=1 -> o_PCEn=1 with o_PCSource=01 in BRANCH. bne with i_Zero=1 -> o_PCEn=0. Both retire.
- Opcode 111111 -> DECODE goes to ILLEGAL. o_Illegal=1 and all strobes 0 for 20 cycles. o_Retired unchanged.
- COUNT_WIDTH=4, run 16 j instructions -> o_Retired reads 15, then 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Sequencing controller for the multicycle MIPS datapath: a Moore FSM that
// drives every datapath select and strobe and counts retired instructions.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [5:0]             i_Opcode,
  input  logic                   i_Zero,
  input  logic                   i_MemReady,
  output logic                   o_PCEn,
  output logic                   o_IorD,
  output logic                   o_MemRead,
  output logic                   o_MemWrite,
  output logic                   o_IRWrite,
  output logic                   o_MemtoReg,
  output logic                   o_RegDst,
  output logic                   o_RegWrite,
  output logic                   o_ALUSrcA,
  output logic [1:0]             o_ALUSrcB,
  output logic [1:0]             o_ALUOp,
  output logic [1:0]             o_PCSource,
  output logic [3:0]             o_State,
  output logic                   o_Illegal,
  output logic [COUNT_WIDTH-1:0] o_Retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IEXEC    = 4'd10,
    S_IWB      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state, state_next;
  logic   retire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset also aborts any in-flight instruction.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_FETCH;
      o_Retired <= '0;
    end else begin
      state <= state_next;
      if (retire) o_Retired <= o_Retired + COUNT_WIDTH'(1);
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    o_PCEn     = 1'b0;
    o_IorD     = 1'b0;
    o_MemRead  = 1'b0;
    o_MemWrite = 1'b0;
    o_IRWrite  = 1'b0;
    o_MemtoReg = 1'b0;
    o_RegDst   = 1'b0;
    o_RegWrite = 1'b0;
    o_ALUSrcA  = 1'b0;
    o_ALUSrcB  = 2'b00;
    o_ALUOp    = 2'b00;
    o_PCSource = 2'b00;
    o_Illegal  = 1'b0;

    case (state)
      S_FETCH: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = 2'b01;
        if (i_MemReady) begin
          o_IRWrite  = 1'b1;
          o_PCEn     = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        o_ALUSrcB = 2'b11;
        case (i_Opcode)
          OP_RTYPE:       state_next = S_EXECUTE;
          OP_LW, OP_SW:   state_next = S_MEMADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:           state_next = S_JUMP;
          OP_ADDI:        state_next = S_IEXEC;
          default:        state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADDR: begin
        o_ALUSrcA  = 1'b1;
        o_ALUSrcB  = 2'b10;
        state_next = (i_Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_IorD    = 1'b1;
        o_MemRead = 1'b1;
        if (i_MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_MemtoReg = 1'b1;
        o_RegWrite = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        o_IorD     = 1'b1;
        o_MemWrite = 1'b1;
        if (i_MemReady) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECUTE: begin
        o_ALUSrcA  = 1'b1;
        o_ALUOp    = 2'b10;
        state_next = S_RWB;
      end
      S_RWB: begin
        o_RegDst   = 1'b1;
        o_RegWrite = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        o_ALUSrcA  = 1'b1;
        o_ALUOp    = 2'b01;
        o_PCSource = 2'b01;
        // opcode bit 0 distinguishes bne from beq, inverting the take sense
        o_PCEn     = i_Zero ^ i_Opcode[0];
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        o_PCSource = 2'b10;
        o_PCEn     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_IEXEC: begin
        o_ALUSrcA  = 1'b1;
        o_ALUSrcB  = 2'b10;
        state_next = S_IWB;
      end
      S_IWB: begin
        o_RegWrite = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        o_Illegal  = 1'b1;
        state_next = S_ILLEGAL;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset holds the state in FETCH, so only the strobes need masking here.
    if (!i_Rst_n) begin
      o_PCEn     = 1'b0;
      o_MemRead  = 1'b0;
      o_MemWrite = 1'b0;
      o_IRWrite  = 1'b0;
      o_RegWrite = 1'b0;
    end
  end

  assign o_State = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus
// hand-written reset-abort, illegal-trap and counter-wrap sequences.
module tb_multicycle_control;

  localparam int CW = 4;

  // Packed control word: {PCEn,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  // RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],Illegal}
  localparam logic [15:0] C_FETCH_RDY  = 16'hA820;
  localparam logic [15:0] C_FETCH_WAIT = 16'h2020;
  localparam logic [15:0] C_DECODE     = 16'h0060;
  localparam logic [15:0] C_MEMADDR    = 16'h00C0;
  localparam logic [15:0] C_MEMREAD    = 16'h6000;
  localparam logic [15:0] C_MEMWB      = 16'h0500;
  localparam logic [15:0] C_MEMWRITE   = 16'h5000;
  localparam logic [15:0] C_EXECUTE    = 16'h0090;
  localparam logic [15:0] C_RWB        = 16'h0300;
  localparam logic [15:0] C_BR_TAKEN   = 16'h808A;
  localparam logic [15:0] C_BR_NOT     = 16'h008A;
  localparam logic [15:0] C_JUMP       = 16'h8004;
  localparam logic [15:0] C_IEXEC      = 16'h00C0;
  localparam logic [15:0] C_IWB        = 16'h0100;
  localparam logic [15:0] C_ILLEGAL    = 16'h0001;
  localparam logic [15:0] C_RESET      = 16'h0020;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic          reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic [CW-1:0] retired;
  logic [15:0]   ctl;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [3:0]  ret;
  } vec_t;

  vec_t vecs[$];

  multicycle_control #(.COUNT_WIDTH(CW)) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Opcode   (opcode),
    .i_Zero     (zero),
    .i_MemReady (mem_ready),
    .o_PCEn     (pc_en),
    .o_IorD     (iord),
    .o_MemRead  (mem_read),
    .o_MemWrite (mem_write),
    .o_IRWrite  (ir_write),
    .o_MemtoReg (mem_to_reg),
    .o_RegDst   (reg_dst),
    .o_RegWrite (reg_write),
    .o_ALUSrcA  (alu_src_a),
    .o_ALUSrcB  (alu_src_b),
    .o_ALUOp    (alu_op),
    .o_PCSource (pc_source),
    .o_State    (state),
    .o_Illegal  (illegal),
    .o_Retired  (retired)
  );

  assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [5:0] op, input logic z, input logic rdy,
                             input logic [3:0] st, input logic [15:0] c, input logic [3:0] ret);
    vec_t r;
    r.op = op; r.z = z; r.rdy = rdy; r.st = st; r.ctl = c; r.ret = ret;
    return r;
  endfunction

  // Drive inputs shortly after a rising edge; outputs are checked at the falling edge.
  task automatic drive(input logic [5:0] op, input logic z, input logic rdy);
    opcode = op; zero = z; mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One j instruction with zero wait states: FETCH, DECODE, JUMP.
  task automatic run_jump();
    drive(6'b000010, 1'b0, 1'b1); tick();
    drive(6'b000010, 1'b0, 1'b1); tick();
    drive(6'b000010, 1'b0, 1'b1); tick();
  endtask

  initial begin
    // R-type, addi, j back to back
    vecs.push_back(v(6'd0,  0, 1, 4'd0,  C_FETCH_RDY, 4'd0));
    vecs.push_back(v(6'd0,  0, 0, 4'd1,  C_DECODE,    4'd0));
    vecs.push_back(v(6'd0,  0, 0, 4'd6,  C_EXECUTE,   4'd0));
    vecs.push_back(v(6'd0,  0, 1, 4'd7,  C_RWB,       4'd0));
    vecs.push_back(v(6'd8,  0, 1, 4'd0,  C_FETCH_RDY, 4'd1));
    vecs.push_back(v(6'd8,  0, 0, 4'd1,  C_DECODE,    4'd1));
    vecs.push_back(v(6'd8,  0, 0, 4'd10, C_IEXEC,     4'd1));
    vecs.push_back(v(6'd8,  0, 0, 4'd11, C_IWB,       4'd1));
    vecs.push_back(v(6'd2,  0, 1, 4'd0,  C_FETCH_RDY, 4'd2));
    vecs.push_back(v(6'd2,  0, 1, 4'd1,  C_DECODE,    4'd2));
    vecs.push_back(v(6'd2,  0, 0, 4'd9,  C_JUMP,      4'd2));
    // beq/bne with both zero-flag values
    vecs.push_back(v(6'd4,  1, 1, 4'd0,  C_FETCH_RDY, 4'd3));
    vecs.push_back(v(6'd4,  1, 1, 4'd1,  C_DECODE,    4'd3));
    vecs.push_back(v(6'd4,  1, 0, 4'd8,  C_BR_TAKEN,  4'd3));
    vecs.push_back(v(6'd5,  1, 1, 4'd0,  C_FETCH_RDY, 4'd4));
    vecs.push_back(v(6'd5,  1, 1, 4'd1,  C_DECODE,    4'd4));
    vecs.push_back(v(6'd5,  1, 1, 4'd8,  C_BR_NOT,    4'd4));
    vecs.push_back(v(6'd4,  0, 1, 4'd0,  C_FETCH_RDY, 4'd5));
    vecs.push_back(v(6'd4,  0, 1, 4'd1,  C_DECODE,    4'd5));
    vecs.push_back(v(6'd4,  0, 1, 4'd8,  C_BR_NOT,    4'd5));
    vecs.push_back(v(6'd5,  0, 1, 4'd0,  C_FETCH_RDY, 4'd6));
    vecs.push_back(v(6'd5,  0, 1, 4'd1,  C_DECODE,    4'd6));
    vecs.push_back(v(6'd5,  0, 0, 4'd8,  C_BR_TAKEN,  4'd6));
    // lw: 2 wait cycles in FETCH, 3 in MEMREAD -> 10 cycles
    vecs.push_back(v(6'd35, 0, 0, 4'd0,  C_FETCH_WAIT, 4'd7));
    vecs.push_back(v(6'd35, 0, 0, 4'd0,  C_FETCH_WAIT, 4'd7));
    vecs.push_back(v(6'd35, 0, 1, 4'd0,  C_FETCH_RDY,  4'd7));
    vecs.push_back(v(6'd35, 0, 0, 4'd1,  C_DECODE,     4'd7));
    vecs.push_back(v(6'd35, 0, 0, 4'd2,  C_MEMADDR,    4'd7));
    vecs.push_back(v(6'd35, 0, 0, 4'd3,  C_MEMREAD,    4'd7));
    vecs.push_back(v(6'd35, 0, 0, 4'd3,  C_MEMREAD,    4'd7));
    vecs.push_back(v(6'd35, 0, 0, 4'd3,  C_MEMREAD,    4'd7));
    vecs.push_back(v(6'd35, 0, 1, 4'd3,  C_MEMREAD,    4'd7));
    vecs.push_back(v(6'd35, 0, 0, 4'd4,  C_MEMWB,      4'd7));
    // sw with one MEMWRITE wait cycle
    vecs.push_back(v(6'd43, 0, 1, 4'd0,  C_FETCH_RDY,  4'd8));
    vecs.push_back(v(6'd43, 0, 0, 4'd1,  C_DECODE,     4'd8));
    vecs.push_back(v(6'd43, 0, 1, 4'd2,  C_MEMADDR,    4'd8));
    vecs.push_back(v(6'd43, 0, 0, 4'd5,  C_MEMWRITE,   4'd8));
    vecs.push_back(v(6'd43, 0, 1, 4'd5,  C_MEMWRITE,   4'd8));
    vecs.push_back(v(6'd0,  0, 0, 4'd0,  C_FETCH_WAIT, 4'd9));

    // Reset state, with memory ready high so the FETCH strobes would fire if unmasked
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset state",   32'(state),   32'd0);
    check("reset ctl",     32'(ctl),     32'(C_RESET));
    check("reset retired", 32'(retired), 32'd0);
    #6 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].z, vecs[i].rdy);
      check($sformatf("row%0d state", i),   32'(state),   32'(vecs[i].st));
      check($sformatf("row%0d ctl", i),     32'(ctl),     32'(vecs[i].ctl));
      check($sformatf("row%0d retired", i), 32'(retired), 32'(vecs[i].ret));
      tick();
    end

    // Reset mid-MEMREAD aborts the lw without counting it
    drive(6'd35, 0, 1); tick();
    drive(6'd35, 0, 1); tick();
    drive(6'd35, 0, 1); tick();
    drive(6'd35, 0, 0);
    check("pre-abort state", 32'(state), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("abort state",   32'(state),   32'd0);
    check("abort ctl",     32'(ctl),     32'(C_FETCH_WAIT & ~16'h2000));
    check("abort retired", 32'(retired), 32'd0);
    mem_ready = 1'b1;
    tick();
    check("held reset state", 32'(state), 32'd0);
    check("held reset ctl",   32'(ctl),   32'(C_RESET));
    #2 rst_n = 1'b1;
    drive(6'd2, 0, 1);
    check("post-reset fetch ctl", 32'(ctl), 32'(C_FETCH_RDY));
    tick();
    check("post-reset decode", 32'(state), 32'd1);
    drive(6'd2, 0, 1); tick();
    drive(6'd2, 0, 1); tick();
    check("post-reset j retired", 32'(retired), 32'd1);

    // Illegal opcode traps for good; retired count stays put
    drive(6'h3F, 0, 1); tick();
    drive(6'h3F, 0, 1); tick();
    for (int c = 0; c < 20; c++) begin
      drive(6'h3F, c[0], c[1]);
      check($sformatf("illegal c%0d state", c),   32'(state),   32'd12);
      check($sformatf("illegal c%0d ctl", c),     32'(ctl),     32'(C_ILLEGAL));
      check($sformatf("illegal c%0d retired", c), 32'(retired), 32'd1);
      tick();
    end

    // Retired counter wraps at 2^CW
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("wrap start", 32'(retired), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      run_jump();
      check($sformatf("wrap j%0d", k), 32'(retired), 32'(k % 16));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
